// File: rtl/packet_switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packet_switch_pkg
//  Description : Shared types and constants for the packet-switch DMA RX path.
//                Provides the drop-gate state type and the CSR drop-threshold
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package packet_switch_pkg;

    // Width of the per-channel drop threshold CSR field, in FIFO words.
    localparam int DMA_DROP_THRESH_W = 16;

    // Packet gate state. SOP waits for the first beat of a packet, PASS
    // forwards the remainder of an accepted packet, DROP discards it.
    typedef enum logic [1:0] {
        SOP  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } drop_gate_state_t;

endpackage : packet_switch_pkg
`default_nettype wire

// File: rtl/dma_rx_drop_skid.sv
`default_nettype none
// ============================================================================
//  Module      : dma_rx_drop_skid
//  Description : Two-entry AXI-Stream skid buffer with registered outputs.
//                Carries an opaque payload (tdata/tkeep/tuser/tlast packed by
//                the parent). Full throughput while i_ready=1, 1-cycle latency.
//  Ports       : clk, rst_n       - clock, synchronous active-low reset
//                i_valid, i_data  - write side; a write is taken when
//                                   i_valid=1 and o_not_full=1
//                o_not_full       - write-side ready (skid entry empty)
//                o_valid, o_data  - registered read side
//                i_ready          - read-side ready
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_rx_drop_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_not_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_main_free;

    // Write-side ready depends only on registered state, so it never forms a
    // combinational path from the downstream ready.
    assign o_not_full  = ~r_skid_valid;
    assign w_in_fire   = i_valid & ~r_skid_valid;
    // Output register can take new data when empty or being read this cycle.
    assign w_main_free = ~r_main_valid | i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Payload registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_data <= r_skid_data;
            end else if (w_in_fire) begin
                r_main_data <= i_data;
            end
        end else if (w_in_fire) begin
            r_skid_data <= i_data;
        end
    end

    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule : dma_rx_drop_skid
`default_nettype wire

// File: rtl/dma_rx_drop_gate.sv
`default_nettype none
// ============================================================================
//  Module      : dma_rx_drop_gate
//  Description : Per-channel DMA RX packet gate. At each start of packet the
//                drop threshold is compared with the DMA FIFO fill level; the
//                whole packet is then forwarded or silently discarded at line
//                rate, so a congested channel never stalls the packet switch.
//  Ports       : clk, rst_n                  - clock, sync active-low reset
//                cfg_drop_en/threshold       - CSR drop controls (SOP-sampled)
//                fifo_fill_level             - DMA FIFO occupancy (SOP-sampled)
//                igr_axis_*                  - ingress AXI-Stream
//                egr_axis_*                  - egress AXI-Stream (registered)
//                stat_drop/pass_pkt_cnt      - saturating packet counters
//  Build macro : DMA_RX_DROP_GATE_STATS_EN - when defined, the statistics
//                counters are implemented; otherwise they read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_rx_drop_gate
    import packet_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 64,
    parameter int FILL_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_drop_en,
    input  logic [DMA_DROP_THRESH_W-1:0] cfg_drop_threshold,
    input  logic [FILL_WIDTH-1:0]        fifo_fill_level,
    input  logic                         igr_axis_tvalid,
    output logic                         igr_axis_tready,
    input  logic [DATA_WIDTH-1:0]        igr_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]      igr_axis_tkeep,
    input  logic [USER_WIDTH-1:0]        igr_axis_tuser,
    input  logic                         igr_axis_tlast,
    output logic                         egr_axis_tvalid,
    input  logic                         egr_axis_tready,
    output logic [DATA_WIDTH-1:0]        egr_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      egr_axis_tkeep,
    output logic [USER_WIDTH-1:0]        egr_axis_tuser,
    output logic                         egr_axis_tlast,
    output logic [CNT_WIDTH-1:0]         stat_drop_pkt_cnt,
    output logic [CNT_WIDTH-1:0]         stat_pass_pkt_cnt
);

    localparam int c_KEEP_W = DATA_WIDTH / 8;
    localparam int c_SKID_W = DATA_WIDTH + c_KEEP_W + USER_WIDTH + 1;
    localparam int c_CMP_W  = (FILL_WIDTH > DMA_DROP_THRESH_W) ? FILL_WIDTH
                                                                : DMA_DROP_THRESH_W;

    drop_gate_state_t    r_state;
    drop_gate_state_t    w_next_state;
    logic                r_started;
    logic                w_accept;
    logic                w_drop_hit;
    logic                w_sop_evt;
    logic                w_fwd_wr;
    logic                w_skid_not_full;
    logic [c_CMP_W-1:0]  w_fill_ext;
    logic [c_CMP_W-1:0]  w_thr_ext;
    logic [c_SKID_W-1:0] w_skid_din;
    logic [c_SKID_W-1:0] w_skid_dout;

    // Drop decision from the live (same-cycle) inputs; it only takes effect
    // on the SOP beat.
    assign w_fill_ext = c_CMP_W'(fifo_fill_level);
    assign w_thr_ext  = c_CMP_W'(cfg_drop_threshold);
    assign w_drop_hit = cfg_drop_en & (w_fill_ext >= w_thr_ext);
    assign w_accept   = igr_axis_tvalid & igr_axis_tready;

    // Holds ingress ready low for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SOP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SOP: begin
                if (w_sop_evt && !igr_axis_tlast) begin
                    w_next_state = w_drop_hit ? DROP : PASS;
                end
            end
            PASS, DROP: begin
                if (w_accept && igr_axis_tlast) begin
                    w_next_state = SOP;
                end
            end
            default: w_next_state = SOP;
        endcase
    end

    // ---------------- output logic ----------------
    // DROP is always ready so discarded packets drain regardless of egress
    // back-pressure. SOP follows skid space even when it will drop.
    always_comb begin
        logic l_ready;
        logic l_fire;
        l_ready = 1'b0;
        if (rst_n && r_started) begin
            case (r_state)
                SOP, PASS: l_ready = w_skid_not_full;
                DROP:      l_ready = 1'b1;
                default:   l_ready = 1'b0;
            endcase
        end
        l_fire          = igr_axis_tvalid & l_ready;
        igr_axis_tready = l_ready;
        w_sop_evt       = l_fire & (r_state == SOP);
        w_fwd_wr        = l_fire & (((r_state == SOP) & ~w_drop_hit) |
                                    (r_state == PASS));
    end

    // ---------------- egress skid buffer ----------------
    assign w_skid_din = {igr_axis_tdata, igr_axis_tkeep, igr_axis_tuser, igr_axis_tlast};

    dma_rx_drop_skid #(
        .WIDTH (c_SKID_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (w_fwd_wr),
        .i_data     (w_skid_din),
        .o_not_full (w_skid_not_full),
        .o_valid    (egr_axis_tvalid),
        .o_data     (w_skid_dout),
        .i_ready    (egr_axis_tready)
    );

    assign {egr_axis_tdata, egr_axis_tkeep, egr_axis_tuser, egr_axis_tlast} = w_skid_dout;

    // ---------------- statistics ----------------
`ifdef DMA_RX_DROP_GATE_STATS_EN
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [CNT_WIDTH-1:0] r_pass_cnt;

    // One increment per packet at its SOP decision; saturate, never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_pass_cnt <= '0;
        end else if (w_sop_evt) begin
            if (w_drop_hit) begin
                if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                end
            end else begin
                if (r_pass_cnt != {CNT_WIDTH{1'b1}}) begin
                    r_pass_cnt <= r_pass_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign stat_drop_pkt_cnt = r_drop_cnt;
    assign stat_pass_pkt_cnt = r_pass_cnt;
`else
    assign stat_drop_pkt_cnt = '0;
    assign stat_pass_pkt_cnt = '0;
`endif

endmodule : dma_rx_drop_gate
`default_nettype wire

// File: tb/tb_dma_rx_drop_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_rx_drop_gate
//  Description : Self-checking bench for dma_rx_drop_gate. A packet table and
//                randomized packets are driven; expected egress beats are kept
//                in a queue built from the drop rule, and packet counts are
//                kept alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_rx_drop_gate;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 64;
    localparam int FW = 16;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          cfg_drop_en;
    logic [15:0]   cfg_drop_threshold;
    logic [FW-1:0] fifo_fill_level;
    logic          igr_axis_tvalid;
    logic          igr_axis_tready;
    logic [DW-1:0] igr_axis_tdata;
    logic [KW-1:0] igr_axis_tkeep;
    logic [UW-1:0] igr_axis_tuser;
    logic          igr_axis_tlast;
    logic          egr_axis_tvalid;
    logic          egr_axis_tready;
    logic [DW-1:0] egr_axis_tdata;
    logic [KW-1:0] egr_axis_tkeep;
    logic [UW-1:0] egr_axis_tuser;
    logic          egr_axis_tlast;
    logic [CW-1:0] stat_drop_pkt_cnt;
    logic [CW-1:0] stat_pass_pkt_cnt;

    dma_rx_drop_gate #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .FILL_WIDTH (FW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_drop_en        (cfg_drop_en),
        .cfg_drop_threshold (cfg_drop_threshold),
        .fifo_fill_level    (fifo_fill_level),
        .igr_axis_tvalid    (igr_axis_tvalid),
        .igr_axis_tready    (igr_axis_tready),
        .igr_axis_tdata     (igr_axis_tdata),
        .igr_axis_tkeep     (igr_axis_tkeep),
        .igr_axis_tuser     (igr_axis_tuser),
        .igr_axis_tlast     (igr_axis_tlast),
        .egr_axis_tvalid    (egr_axis_tvalid),
        .egr_axis_tready    (egr_axis_tready),
        .egr_axis_tdata     (egr_axis_tdata),
        .egr_axis_tkeep     (egr_axis_tkeep),
        .egr_axis_tuser     (egr_axis_tuser),
        .egr_axis_tlast     (egr_axis_tlast),
        .stat_drop_pkt_cnt  (stat_drop_pkt_cnt),
        .stat_pass_pkt_cnt  (stat_pass_pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        bit en;
        int thr;
        int fill;
        int fill_mid;
        int nbeats;
        int rmode;      // egress ready: 0 always, 1 never, 2 random
        bit exp_drop;
        bit nostall;    // every ingress beat must be taken in one cycle
    } vec_t;

    beat_t exp_q[$];
    int    n_checks  = 0;
    int    n_pass    = 0;
    int    exp_pass  = 0;
    int    exp_drop  = 0;
    int    rdy_mode  = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic chk_cnt();
`ifdef DMA_RX_DROP_GATE_STATS_EN
        chk("pass_cnt", stat_pass_pkt_cnt, exp_pass);
        chk("drop_cnt", stat_drop_pkt_cnt, exp_drop);
`else
        chk("pass_cnt", stat_pass_pkt_cnt, 0);
        chk("drop_cnt", stat_drop_pkt_cnt, 0);
`endif
    endtask

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called just after a negedge with the beat on the bus; returns just
    // after the negedge following the accepting posedge.
    task automatic wait_accept(inout int stalls);
        int n;
        n = 0;
        while (!igr_axis_tready) begin
            stalls++;
            n++;
            if (n > 500) begin
                chk("accept_timeout", 1, 0);
                finish_now();
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_pkt(input bit en, input int thr, input int fill, input int fill_mid,
                            input int nb, input bit fwd, output int stalls);
        beat_t bt;
        stalls = 0;
        for (int b = 0; b < nb; b++) begin
            bt.data = rnd512();
            bt.keep = {$urandom, $urandom};
            bt.user = {$urandom, $urandom};
            bt.last = (b == nb - 1);
            igr_axis_tvalid = 1'b1;
            igr_axis_tdata  = bt.data;
            igr_axis_tkeep  = bt.keep;
            igr_axis_tuser  = bt.user;
            igr_axis_tlast  = bt.last;
            if (b == 0) begin
                cfg_drop_en        = en;
                cfg_drop_threshold = 16'(thr);
                fifo_fill_level    = FW'(fill);
            end else begin
                // Config wiggles mid-packet must have no effect.
                cfg_drop_en        = 1'($urandom_range(0, 1));
                cfg_drop_threshold = 16'($urandom);
                fifo_fill_level    = FW'(fill_mid);
            end
            if (fwd) exp_q.push_back(bt);
            wait_accept(stalls);
        end
        igr_axis_tvalid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        if (exp_q.size() != 0) finish_now();
        @(negedge clk);
    endtask

    // Egress monitor / ready driver: everything on the falling edge.
    initial begin : monitor
        beat_t b;
        beat_t prev;
        bit    prev_stall;
        prev_stall = 1'b0;
        egr_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", egr_axis_tvalid, 1);
                chk("stall_data", egr_axis_tdata, prev.data);
                chk("stall_side", {egr_axis_tkeep, egr_axis_tuser, egr_axis_tlast},
                    {prev.keep, prev.user, prev.last});
            end
            case (rdy_mode)
                0:       egr_axis_tready = 1'b1;
                1:       egr_axis_tready = 1'b0;
                default: egr_axis_tready = 1'($urandom_range(0, 1));
            endcase
            if (egr_axis_tvalid && egr_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("egr_data", egr_axis_tdata, b.data);
                    chk("egr_keep", egr_axis_tkeep, b.keep);
                    chk("egr_user", egr_axis_tuser, b.user);
                    chk("egr_last", egr_axis_tlast, b.last);
                end
            end
            prev_stall = egr_axis_tvalid && !egr_axis_tready;
            prev.data  = egr_axis_tdata;
            prev.keep  = egr_axis_tkeep;
            prev.user  = egr_axis_tuser;
            prev.last  = egr_axis_tlast;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[18];
        int   stalls;
        bit   en;
        int   thr;
        int   fill;
        int   nb;
        bit   drop;

        tbl[0]  = '{1'b0, 4,     100,   100, 5,  0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4,     100,   100, 5,  0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 4,     100,   100, 5,  0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8,     8,     8,   12, 1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 8,     7,     7,   4,  0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8,     0,     50,  10, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8,     50,    50,  10, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 10,    20,    20,  1,  0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 10,    0,     0,   1,  0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 10,    20,    20,  1,  0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 10,    0,     0,   1,  0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 10,    20,    20,  1,  0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 10,    0,     0,   1,  0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 0,     0,     0,   3,  0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 0,     30,    30,  3,  0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 10,    5,     500, 64, 2, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 65535, 65535, 0,   2,  0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 65535, 65534, 0,   2,  0, 1'b0, 1'b0};

        rst_n              = 1'b0;
        igr_axis_tvalid    = 1'b0;
        igr_axis_tdata     = '0;
        igr_axis_tkeep     = '0;
        igr_axis_tuser     = '0;
        igr_axis_tlast     = 1'b0;
        cfg_drop_en        = 1'b0;
        cfg_drop_threshold = '0;
        fifo_fill_level    = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tready", igr_axis_tready, 0);
        chk("rst_egr_valid", egr_axis_tvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_tready", igr_axis_tready, 0);
        chk_cnt();
        @(negedge clk);
        #1;
        chk("ready_after_rst", igr_axis_tready, 1);

        // Table-driven packets.
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rmode == 1) wait_empty();
            rdy_mode = tbl[i].rmode;
            send_pkt(tbl[i].en, tbl[i].thr, tbl[i].fill, tbl[i].fill_mid,
                     tbl[i].nbeats, !tbl[i].exp_drop, stalls);
            if (tbl[i].nostall) chk("no_stall", stalls, 0);
            if (tbl[i].exp_drop) exp_drop++;
            else                 exp_pass++;
        end
        rdy_mode = 0;
        wait_empty();
        chk_cnt();

        // One-cycle latency from an accepted beat to egress valid.
        chk("idle_egr_valid", egr_axis_tvalid, 0);
        igr_axis_tvalid = 1'b1;
        igr_axis_tdata  = rnd512();
        igr_axis_tkeep  = '1;
        igr_axis_tuser  = 64'h1234;
        igr_axis_tlast  = 1'b1;
        cfg_drop_en     = 1'b0;
        exp_q.push_back('{igr_axis_tdata, igr_axis_tkeep, igr_axis_tuser, 1'b1});
        chk("lat_tready", igr_axis_tready, 1);
        @(negedge clk);
        igr_axis_tvalid = 1'b0;
        chk("lat_egr_valid", egr_axis_tvalid, 1);
        exp_pass++;
        wait_empty();

        // Randomized packets against the drop rule.
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            en   = 1'($urandom_range(0, 1));
            thr  = $urandom_range(0, 20);
            fill = $urandom_range(0, 25);
            nb   = $urandom_range(1, 6);
            drop = en && (fill >= thr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_pkt(en, thr, fill, $urandom_range(0, 25), nb, !drop, stalls);
            if (drop) exp_drop++;
            else      exp_pass++;
        end
        rdy_mode = 0;
        wait_empty();
        chk_cnt();

        // Reset in the middle of a dropped 20-beat packet.
        igr_axis_tvalid    = 1'b1;
        igr_axis_tlast     = 1'b0;
        cfg_drop_en        = 1'b1;
        cfg_drop_threshold = 16'd5;
        fifo_fill_level    = 16'd10;
        stalls = 0;
        for (int b = 0; b < 8; b++) begin
            igr_axis_tdata = rnd512();
            wait_accept(stalls);
        end
        chk("drop_no_stall", stalls, 0);
        rst_n           = 1'b0;
        igr_axis_tvalid = 1'b0;
        #1;
        chk("midrst_tready", igr_axis_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_pass = 0;
        exp_drop = 0;
        chk("midrst_egr_valid", egr_axis_tvalid, 0);
        chk("midrst_tready_after", igr_axis_tready, 0);
        chk_cnt();
        @(negedge clk);
        #1;
        chk("midrst_ready_back", igr_axis_tready, 1);
        // Would be discarded if the gate were still in the dropped packet.
        send_pkt(1'b1, 5, 0, 0, 3, 1'b1, stalls);
        exp_pass++;
        wait_empty();
        chk_cnt();

        finish_now();
    end

endmodule : tb_dma_rx_drop_gate
`default_nettype wire

// File: doc/dma_rx_drop_gate.md
Name: dma_rx_drop_gate

Overview:
- Per-channel packet gate that sits directly downstream of the DMA RX demux CSR block.
- Consumes one channel's drop enable and drop threshold, and compares the threshold against the channel's DMA RX FIFO fill level at each start of packet (SOP).
- Either forwards the whole AXI-Stream packet or silently discards it, so a congested DMA channel never stalls the shared packet switch.
- One instance per DMA channel (0..2).

Parameters:
- DATA_WIDTH, 512, tdata width in bits.
- USER_WIDTH, 64, tuser sideband width (passed through unchanged).
- FILL_WIDTH, 16, width of the FIFO fill-level input, in words.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_drop_en  in  1  drop enable from CSR.
- cfg_drop_threshold  in  16  drop threshold from CSR, in FIFO words.
- fifo_fill_level  in  FILL_WIDTH  current downstream DMA FIFO occupancy.
- igr_axis_tvalid  in  1  ingress valid.
- igr_axis_tready  out  1  ingress ready.
- igr_axis_tdata  in  DATA_WIDTH  ingress data.
- igr_axis_tkeep  in  DATA_WIDTH/8  ingress byte keep.
- igr_axis_tuser  in  USER_WIDTH  ingress sideband.
- igr_axis_tlast  in  1  ingress end of packet.
- egr_axis_tvalid  out  1  egress valid.
- egr_axis_tready  in  1  egress ready.
- egr_axis_tdata  out  DATA_WIDTH  egress data.
- egr_axis_tkeep  out  DATA_WIDTH/8  egress byte keep.
- egr_axis_tuser  out  USER_WIDTH  egress sideband.
- egr_axis_tlast  out  1  egress end of packet.
- stat_drop_pkt_cnt  out  CNT_WIDTH  dropped-packet count (feature only).
- stat_pass_pkt_cnt  out  CNT_WIDTH  forwarded-packet count (feature only).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to SOP.
  - Skid buffer is emptied; egr_axis_tvalid=0.
  - igr_axis_tready=0 during reset and for the first cycle after it.
  - Counters are cleared to 0.
  - A packet in flight at reset is abandoned; the next accepted beat is treated as SOP.
- Ingress beat accepted means igr_axis_tvalid & igr_axis_tready.
- State machine:
  - SOP: on an accepted beat, evaluate drop = cfg_drop_en & (fifo_fill_level >= {zero-extended} cfg_drop_threshold).
    - If drop: the beat is discarded. If tlast=0 go to DROP, else stay in SOP.
    - If not drop: the beat is written to the skid buffer. If tlast=0 go to PASS, else stay in SOP.
  - PASS: accepted beats are written to the skid buffer. An accepted tlast returns the state to SOP.
  - DROP: accepted beats are discarded. An accepted tlast returns the state to SOP.
- Ready rules:
  - igr_axis_tready = skid_not_full in SOP and PASS.
  - igr_axis_tready = 1 in DROP, so dropped packets drain at line rate independent of egr_axis_tready.
  - In SOP, tready follows skid space even when the decision will be drop. The decision uses the same-cycle fill level and is not lookahead.
- Configuration handling:
  - cfg_drop_en, cfg_drop_threshold and fifo_fill_level are sampled only at the SOP beat.
  - Changes mid-packet have no effect until the next SOP.
  - threshold=0 with enable=1 drops every packet.
  - enable=0 never drops, regardless of threshold.
- Egress path:
  - Uses a 2-entry skid buffer with registered outputs.
  - Latency is 1 cycle from an accepted ingress beat to egr_axis_tvalid when egress is not back-pressured.
  - Full throughput: 1 beat per cycle sustained while egr_axis_tready=1.
  - egr_axis_* stays stable while tvalid=1 and tready=0, per AXI-Stream rules.
- Packets are never truncated; every forwarded packet is complete from SOP to tlast.
- Counters:
  - Increment on the SOP decision beat (drop or pass), once per packet.
  - Saturate at all-ones with no wrap.

Optional Feature:
- Macro DMA_RX_DROP_GATE_STATS_EN.
- Defined: stat_drop_pkt_cnt and stat_pass_pkt_cnt are implemented as described above.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.
- Datapath behaviour is identical in both cases.

Decomposition:
- packet_switch_pkg gets:
  - typedef drop_gate_state_t {SOP, PASS, DROP}.
  - Localparam DMA_DROP_THRESH_W = 16.
- One sub-module, dma_rx_drop_skid: the 2-entry AXI-Stream skid buffer carrying {tdata, tkeep, tuser, tlast}, with its own valid/ready and not_full output.

Test Plan:
1. enable=0, threshold=4, fill=100; send 3 packets of 5 beats -> all 15 beats appear on egress in order; pass_cnt=3, drop_cnt=0.
2. enable=1, threshold=8; fill=8 at SOP of packet A, fill=7 at SOP of packet B -> A fully dropped with igr_axis_tready=1 throughout even when egr_axis_tready=0; B forwarded; drop_cnt=1, pass_cnt=1.
3. enable=1, threshold=8, fill=0 at SOP then raised to 50 mid-packet -> the whole 10-beat packet is forwarded; the next packet with fill=50 is dropped.
4. Single-beat packets (tlast on SOP) back-to-back, alternating fill 20/0 with threshold=10 -> odd packets dropped, even packets forwarded, 1 beat/cycle sustained, state remains SOP.
5. egr_axis_tready toggling randomly during a forwarded 64-beat packet -> no beat lost or duplicated, outputs stable while stalled, 1-cycle latency when tready=1.
6. Assert rst_n=0 for 1 cycle mid-drop of a 20-beat packet -> egr_axis_tvalid=0 and counters=0 after reset; the next accepted beat is evaluated as SOP.
